// File: rtl/elixirchip_es1_spu_op_or_checker.sv
// Response monitor for the ES1 SPU bitwise-OR op: a golden OR model runs through
// the same cke-gated latency as the op, and its output is compared against m_data.
//
// state  | meaning
// WARMUP | model pipeline filling; no compares yet
// CHECK  | compares live, no mismatch seen so far
// FAIL   | compares live, first mismatch captured and frozen (left only by reset)
module elixirchip_es1_spu_op_or_checker #(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA = '1,
    parameter int    COUNT_BITS = 16,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  enable,
    input  logic [DATA_BITS-1:0]  s_data0,
    input  logic [DATA_BITS-1:0]  s_data1,
    input  logic                  s_clear,
    input  logic                  s_valid,
    input  logic [DATA_BITS-1:0]  m_data,
    output logic [DATA_BITS-1:0]  exp_data,
    output logic                  err,
    output logic [COUNT_BITS-1:0] err_count,
    output logic [COUNT_BITS-1:0] check_count,
    output logic [DATA_BITS-1:0]  first_exp,
    output logic [DATA_BITS-1:0]  first_act,
    output logic [COUNT_BITS-1:0] first_idx,
    output logic                  armed
);

    localparam int WARM_BITS = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_CHECK  = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    state_t               state;
    logic [WARM_BITS-1:0] warm_cnt;
    data_t                stage [LATENCY];
    logic                 mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= CLEAR_DATA;
            end
        end else if (cke) begin
            if (s_clear) begin
                stage[0] <= CLEAR_DATA;
            end else if (s_valid) begin
                stage[0] <= s_data0 | s_data1;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign exp_data = stage[LATENCY-1];

    // Case inequality so an undriven or X result from the op is a mismatch in simulation.
    assign mismatch = (m_data !== exp_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_WARMUP;
            warm_cnt    <= WARM_BITS'(LATENCY - 1);
            armed       <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            check_count <= '0;
            first_exp   <= '0;
            first_act   <= '0;
            first_idx   <= '0;
        end else if (cke) begin
            case (state)
                ST_WARMUP: begin
                    if (warm_cnt == '0) begin
                        armed <= 1'b1;
                        state <= ST_CHECK;
                    end else begin
                        warm_cnt <= warm_cnt - 1'b1;
                    end
                end
                ST_CHECK, ST_FAIL: begin
                    if (enable) begin
                        if (check_count != '1) begin
                            check_count <= check_count + 1'b1;
                        end
                        if (mismatch) begin
                            err <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (state == ST_CHECK) begin
                                first_exp <= exp_data;
                                first_act <= m_data;
                                first_idx <= check_count;
                                state     <= ST_FAIL;
                            end
                        end
                    end
                end
                default: state <= ST_WARMUP;
            endcase
        end
    end

    if (SIMULATION == "true") begin : g_sim_report
        always @(posedge clk) begin
            if (!reset && cke && enable && armed && mismatch) begin
                $error("%s or-checker mismatch exp=%h act=%h debug=%s", DEVICE, exp_data, m_data, DEBUG);
            end
        end
    end

endmodule
